// File: rtl/upg_pkg.sv
// upg_pkg: shared types and constants for the UART upgrade loader.
// Revision 1.0
`default_nettype none

package upg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } upg_state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_PAR   = 3'd3,
    RX_STOP  = 3'd4
  } rx_state_e;

  localparam logic [7:0] UPG_SYNC_BYTE = 8'hA5;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/upg_uart_rx.sv
// upg_uart_rx: 2-FF synchronised UART receiver, 8N1 or 8E1 when UPG_PARITY_EN is defined.
// Revision 1.0
`default_nettype none

module upg_uart_rx
  import upg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 86
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_frame_err
`ifdef UPG_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int unsigned CW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned C_HALF = CLKS_PER_BIT / 2;

  rx_state_e       r_state, w_next;
  logic            r_sync1, r_sync2, r_prev;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_vld, r_ferr;
  logic            w_fall, w_half, w_full, w_par_bad;

  assign w_fall = r_prev & ~r_sync2;
  assign w_half = (r_cnt == CW'(C_HALF - 1));
  assign w_full = (r_cnt == CW'(CLKS_PER_BIT - 1));

`ifdef UPG_PARITY_EN
  logic r_par, r_perr;
  assign w_par_bad    = ^{r_shift, r_par};
  assign o_parity_err = r_perr;
`else
  assign w_par_bad = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_half) w_next = r_sync2 ? RX_IDLE : RX_DATA;
`ifdef UPG_PARITY_EN
      RX_DATA:  if (w_full && r_bit == 3'd7) w_next = RX_PAR;
`else
      RX_DATA:  if (w_full && r_bit == 3'd7) w_next = RX_STOP;
`endif
      RX_PAR:   if (w_full) w_next = RX_STOP;
      RX_STOP:  if (w_full) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UPG_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_state <= w_next;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UPG_PARITY_EN
      r_perr  <= 1'b0;
`endif
      // Bit timer restarts on every state change so each phase counts from its own entry.
      if (r_state != w_next || w_full) r_cnt <= '0;
      else                             r_cnt <= r_cnt + CW'(1);

      case (r_state)
        RX_IDLE: r_bit <= '0;
        RX_DATA: if (w_full) begin
          r_shift <= {r_sync2, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
        end
`ifdef UPG_PARITY_EN
        RX_PAR:  if (w_full) r_par <= r_sync2;
`endif
        RX_STOP: if (w_full) begin
          r_vld  <= r_sync2 & ~w_par_bad;
          r_ferr <= ~r_sync2;
`ifdef UPG_PARITY_EN
          r_perr <= r_sync2 & w_par_bad;
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_byte      = r_shift;
  assign o_byte_vld  = r_vld;
  assign o_frame_err = r_ferr;

endmodule

`default_nettype wire

// File: rtl/uart_upg_loader.sv
// uart_upg_loader: UART frame loader driving the upgrade memory write port; 8E1 when UPG_PARITY_EN is defined.
// Revision 1.0
`default_nettype none

module uart_upg_loader
  import upg_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 10_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned TIMEOUT_BITS = 1024
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_n_i,
  input  logic              upg_rx_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_busy_o,
  output logic              upg_err_o
);

  localparam int unsigned C_CPB       = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned C_TO_CYCLES = TIMEOUT_BITS * C_CPB;
  localparam int unsigned C_TO_W      = $clog2(C_TO_CYCLES + 1);
  localparam int unsigned C_MAX_WORDS = 2 ** ADDR_W;

  upg_state_e        r_state, w_next;
  logic [7:0]        w_byte;
  logic              w_vld, w_ferr, w_perr;
  logic [7:0]        r_cnt_lo;
  logic [15:0]       r_left;
  logic [ADDR_W-1:0] r_adr, r_adr_o;
  logic [23:0]       r_dat;
  logic [31:0]       r_dat_o;
  logic [1:0]        r_idx;
  logic              r_err;
  logic [C_TO_W-1:0] r_to;
  logic [15:0]       w_count;
  logic              w_busy, w_timeout, w_abort, w_cnt_bad;

  upg_uart_rx #(
    .CLKS_PER_BIT (C_CPB)
  ) u_rx (
    .clk          (upg_clk_i),
    .rst_n        (upg_rst_n_i),
    .i_rx         (upg_rx_i),
    .o_byte       (w_byte),
    .o_byte_vld   (w_vld),
    .o_frame_err  (w_ferr)
`ifdef UPG_PARITY_EN
    ,
    .o_parity_err (w_perr)
`endif
  );

`ifndef UPG_PARITY_EN
  assign w_perr = 1'b0;
`endif

  assign w_count   = {w_byte, r_cnt_lo};
  assign w_busy    = (r_state == CNT_LO) || (r_state == CNT_HI) ||
                     (r_state == DATA)   || (r_state == WRITE);
  assign w_timeout = w_busy && (r_to == C_TO_W'(C_TO_CYCLES - 1));
  assign w_abort   = w_busy && (w_ferr || w_perr || w_timeout);
  assign w_cnt_bad = (32'(w_count) > C_MAX_WORDS);

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_vld && w_byte == UPG_SYNC_BYTE) w_next = CNT_LO;
        CNT_LO:  if (w_vld) w_next = CNT_HI;
        CNT_HI:  if (w_vld) begin
          if (w_count == 16'd0) w_next = DONE;
          else if (w_cnt_bad)   w_next = IDLE;
          else                  w_next = DATA;
        end
        DATA:    if (w_vld && r_idx == 2'd3) w_next = WRITE;
        WRITE:   w_next = (r_left == 16'd1) ? DONE : DATA;
        DONE:    w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_n_i) begin
      r_state  <= IDLE;
      r_cnt_lo <= '0;
      r_left   <= '0;
      r_adr    <= '0;
      r_adr_o  <= '0;
      r_dat    <= '0;
      r_dat_o  <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_to     <= '0;
    end else begin
      r_state <= w_next;

      if (w_busy && !w_vld) r_to <= r_to + C_TO_W'(1);
      else                  r_to <= '0;

      if (w_ferr || w_perr || w_timeout || (r_state == CNT_HI && w_vld && w_cnt_bad))
        r_err <= 1'b1;

      case (r_state)
        IDLE: begin
          r_adr <= '0;
          r_idx <= '0;
        end
        CNT_LO: if (w_vld) r_cnt_lo <= w_byte;
        CNT_HI: if (w_vld) r_left <= w_count;
        DATA: if (w_vld && !w_abort) begin
          r_idx <= r_idx + 2'd1;
          case (r_idx)
            2'd0: r_dat[7:0]   <= w_byte;
            2'd1: r_dat[15:8]  <= w_byte;
            2'd2: r_dat[23:16] <= w_byte;
            default: begin
              // Output registers load only on a complete word so a dropped frame leaves them untouched.
              r_dat_o <= {w_byte, r_dat};
              r_adr_o <= r_adr;
            end
          endcase
        end
        WRITE: begin
          r_adr  <= r_adr + ADDR_W'(1);
          r_left <= r_left - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign upg_wen_o  = (r_state == WRITE);
  assign upg_adr_o  = r_adr_o;
  assign upg_dat_o  = r_dat_o;
  assign upg_done_o = (r_state == DONE);
  assign upg_busy_o = w_busy;
  assign upg_err_o  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_upg_loader.sv
// tb_uart_upg_loader: directed bench for the UART upgrade loader (CLKS_PER_BIT=10, TIMEOUT_BITS=32).
// Revision 1.0
`default_nettype none

module tb_uart_upg_loader;

  localparam int CPB = 10;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        wen;
  logic [13:0] adr;
  logic [31:0] dat;
  logic        done;
  logic        busy;
  logic        err;

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_wr  = 0;
  logic [13:0] wr_adr [64];
  logic [31:0] wr_dat [64];
  logic [7:0]  frame1 [11] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef UPG_PARITY_EN
  logic        par_flip = 1'b0;
`endif

  uart_upg_loader #(
    .CLK_HZ       (10_000_000),
    .BAUD         (1_000_000),
    .ADDR_W       (14),
    .TIMEOUT_BITS (32)
  ) dut (
    .upg_clk_i   (clk),
    .upg_rst_n_i (rst_n),
    .upg_rx_i    (rx),
    .upg_wen_o   (wen),
    .upg_adr_o   (adr),
    .upg_dat_o   (dat),
    .upg_done_o  (done),
    .upg_busy_o  (busy),
    .upg_err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wen) begin
      if (n_wr < 64) begin
        wr_adr[n_wr] = adr;
        wr_dat[n_wr] = dat;
      end
      n_wr = n_wr + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish within 200000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
`ifdef UPG_PARITY_EN
    rx = (^b) ^ par_flip;
    idle(CPB);
`endif
    rx = stop_v;
    idle(CPB);
    rx = 1'b1;
  endtask

  task automatic send_frame1();
    for (int i = 0; i < 11; i++) send_byte(frame1[i], 1'b1);
    idle(5);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic chk_frame1(input string t, input int base);
    chk({t, "_nwr"},  32'(n_wr - base), 32'd2);
    chk({t, "_adr0"}, 32'(wr_adr[base]), 32'd0);
    chk({t, "_dat0"}, wr_dat[base], 32'h12345678);
    chk({t, "_adr1"}, 32'(wr_adr[base+1]), 32'd1);
    chk({t, "_dat1"}, wr_dat[base+1], 32'hDEADBEEF);
    chk({t, "_done"}, 32'(done), 32'd1);
    chk({t, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    rx    = 1'b1;
    rst_n = 1'b0;
    idle(3);
    chk("rst_wen",  32'(wen),  32'd0);
    chk("rst_adr",  32'(adr),  32'd0);
    chk("rst_dat",  dat,       32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    rst_n = 1'b1;
    idle(3);

    // Basic two-word frame
    base = n_wr;
    send_frame1();
    chk_frame1("t1", base);
    chk("t1_err", 32'(err), 32'd0);

    // Garbage before sync byte is ignored
    do_reset();
    base = n_wr;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(5);
    chk("t2_prewen", 32'(n_wr - base), 32'd0);
    chk("t2_prebusy", 32'(busy), 32'd0);
    send_frame1();
    chk_frame1("t2", base);
    chk("t2_err", 32'(err), 32'd0);

    // Zero word count completes immediately
    do_reset();
    base = n_wr;
    send_byte(8'hA5, 1'b1);
    idle(2);
    chk("t3_busy_sync", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b1);
    chk("t3_done_lo", 32'(done), 32'd0);
    send_byte(8'h00, 1'b1);
    idle(2);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_nwr",  32'(n_wr - base), 32'd0);

    // Count one beyond the address space
    do_reset();
    base = n_wr;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h40, 1'b1);
    idle(5);
    chk("t4_err",  32'(err),  32'd1);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_nwr",  32'(n_wr - base), 32'd0);
    send_frame1();
    chk_frame1("t4r", base);
    chk("t4r_err", 32'(err), 32'd1);

    // Framing error on a data byte drops the partial word
    do_reset();
    base = n_wr;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle(CPB);
    chk("t5_err",  32'(err),  32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_nwr",  32'(n_wr - base), 32'd0);
    send_frame1();
    chk_frame1("t5r", base);

    // Reset mid-frame
    do_reset();
    base = n_wr;
    for (int i = 0; i < 5; i++) send_byte(frame1[i], 1'b1);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    idle(1);
    chk("t6_wen",  32'(wen),  32'd0);
    chk("t6_adr",  32'(adr),  32'd0);
    chk("t6_dat",  dat,       32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err",  32'(err),  32'd0);
    rst_n = 1'b1;
    idle(3);
    send_frame1();
    chk_frame1("t6r", base);

    // Inter-byte timeout (32 bit times = 320 cycles)
    do_reset();
    base = n_wr;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(250);
    chk("t7_err_early",  32'(err),  32'd0);
    chk("t7_busy_early", 32'(busy), 32'd1);
    idle(150);
    chk("t7_err",  32'(err),  32'd1);
    chk("t7_busy", 32'(busy), 32'd0);
    send_frame1();
    chk_frame1("t7r", base);

`ifdef UPG_PARITY_EN
    do_reset();
    base = n_wr;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    par_flip = 1'b1;
    send_byte(8'h5A, 1'b1);
    par_flip = 1'b0;
    idle(5);
    chk("t8_err",  32'(err),  32'd1);
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_nwr",  32'(n_wr - base), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
